// File: rtl/bf_pkg.sv
// Shared types for the Brainfuck execution core.
// Opcode and state encodings plus default data/address widths.
package bf_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;

    typedef enum logic [2:0] {
        OP_NOP        = 3'd0,
        OP_INC_PTR    = 3'd1,
        OP_DEC_PTR    = 3'd2,
        OP_INC_VAL    = 3'd3,
        OP_DEC_VAL    = 3'd4,
        OP_PUT        = 3'd5,
        OP_LOOP_BEGIN = 3'd6,
        OP_LOOP_END   = 3'd7
    } opcode_e;

    typedef enum logic {
        ST_EXEC = 1'b0,
        ST_SKIP = 1'b1
    } state_e;

endpackage

// File: rtl/bf_loop_stack.sv
// LIFO of loop-return addresses for bf_core.
// BF_CORE_STACK_CHECK_EN: push when full is dropped instead of overwriting top.
module bf_loop_stack
    import bf_pkg::*;
#(
    parameter int STACK_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] din,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty
);

    localparam int PW = $clog2(STACK_DEPTH) + 1;
    localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PW-1:0]     sp_q;
    logic [PW-1:0]     sp_d;
    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [IW-1:0]     top_idx;
    logic [IW-1:0]     wr_idx;
    logic              wr_en;

    assign full    = (sp_q == PW'(STACK_DEPTH));
    assign empty   = (sp_q == '0);
    // An empty stack reads entry 0 rather than wrapping the index.
    assign top_idx = empty ? '0 : IW'(sp_q - PW'(1));
    assign top     = mem[top_idx];

    always_comb begin
        wr_en  = 1'b0;
        wr_idx = IW'(sp_q);
        sp_d   = sp_q;
        if (push && !full) begin
            wr_en = 1'b1;
            sp_d  = sp_q + PW'(1);
        end else if (push) begin
`ifndef BF_CORE_STACK_CHECK_EN
            wr_en  = 1'b1;
            wr_idx = top_idx;
`endif
        end else if (pop && !empty) begin
            sp_d = sp_q - PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

endmodule

// File: rtl/bf_core.sv
// Brainfuck execution core: one opcode per cycle, EXEC/SKIP loop control.
// BF_CORE_STACK_CHECK_EN enables the sticky stack_err over/underflow flag.
module bf_core
    import bf_pkg::*;
#(
    parameter int RAM_SIZE    = 64,
    parameter int STACK_DEPTH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       halt,
    input  logic [2:0] opecode,
    input  logic [7:0] ram_addr,
    input  logic [7:0] ram_val,
    output logic [7:0] next_ram_addr,
    output logic [7:0] next_ram_val,
    output logic       cout,
    output logic [7:0] rom_addr,
    output logic       stack_err
);

    localparam int DW = $clog2(STACK_DEPTH) + 1;
    localparam logic [DW-1:0] DEPTH_MAX = '1;
    localparam logic [ADDR_W-1:0] PTR_MASK = ADDR_W'(RAM_SIZE - 1);

    opcode_e           op;
    state_e            state_q;
    state_e            state_d;
    logic [DW-1:0]     depth_q;
    logic [DW-1:0]     depth_d;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] top;
    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic              ovf;
    logic              unf;
    logic              zero;

    assign op   = opcode_e'(opecode);
    assign zero = (ram_val == '0);

    bf_loop_stack #(
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (rom_addr),
        .top   (top),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        next_ram_addr = ram_addr;
        next_ram_val  = ram_val;
        cout          = 1'b0;
        state_d       = state_q;
        depth_d       = depth_q;
        pc_d          = rom_addr;
        push          = 1'b0;
        pop           = 1'b0;
        ovf           = 1'b0;
        unf           = 1'b0;
        if (!halt) begin
            pc_d = rom_addr + 8'd1;
            unique case (state_q)
                ST_EXEC: begin
                    unique case (op)
                        OP_NOP: ;
                        OP_INC_PTR:
                            next_ram_addr = (ram_addr + 8'd1) & PTR_MASK;
                        OP_DEC_PTR:
                            next_ram_addr = (ram_addr - 8'd1) & PTR_MASK;
                        OP_INC_VAL:
                            next_ram_val = ram_val + 8'd1;
                        OP_DEC_VAL:
                            next_ram_val = ram_val - 8'd1;
                        OP_PUT:
                            cout = 1'b1;
                        OP_LOOP_BEGIN: begin
                            if (!zero) begin
                                push = 1'b1;
                                ovf  = full;
                            end else begin
                                state_d = ST_SKIP;
                                depth_d = DW'(1);
                            end
                        end
                        OP_LOOP_END: begin
                            if (zero) begin
                                pop = 1'b1;
                                unf = empty;
                            end else if (!empty) begin
                                pc_d = top + 8'd1;
                            end else begin
`ifdef BF_CORE_STACK_CHECK_EN
                                unf = 1'b1;
`else
                                pc_d = top + 8'd1;
`endif
                            end
                        end
                    endcase
                end
                ST_SKIP: begin
                    // Only brackets matter here; depth finds the partner.
                    unique case (op)
                        OP_LOOP_BEGIN: begin
                            if (depth_q != DEPTH_MAX) begin
                                depth_d = depth_q + DW'(1);
                            end
                        end
                        OP_LOOP_END: begin
                            if (depth_q <= DW'(1)) begin
                                depth_d = '0;
                                state_d = ST_EXEC;
                            end else begin
                                depth_d = depth_q - DW'(1);
                            end
                        end
                        default: ;
                    endcase
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_addr <= '0;
            state_q  <= ST_EXEC;
            depth_q  <= '0;
        end else begin
            rom_addr <= pc_d;
            state_q  <= state_d;
            depth_q  <= depth_d;
        end
    end

`ifdef BF_CORE_STACK_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stack_err <= 1'b0;
        end else if (ovf || unf) begin
            stack_err <= 1'b1;
        end
    end
`else
    logic unused_err;
    assign unused_err = ovf | unf;
    assign stack_err  = 1'b0;
`endif

endmodule

// File: tb/tb_bf_core.sv
// Directed testbench for bf_core with ROM and falling-edge RAM models.
// Stack-check expectations follow BF_CORE_STACK_CHECK_EN.
module tb_bf_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       halt;
    logic [2:0] opecode;
    logic [7:0] ram_addr;
    logic [7:0] ram_val;
    logic [7:0] next_ram_addr;
    logic [7:0] next_ram_val;
    logic       cout;
    logic [7:0] rom_addr;
    logic       stack_err;

    logic [2:0] rom [256];
    logic [7:0] mem [64];

    int checks   = 0;
    int failures = 0;

`ifdef BF_CORE_STACK_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    always #5 clk = ~clk;

    assign opecode = rom[rom_addr];
    assign ram_val = mem[ram_addr[5:0]];

    bf_core #(
        .RAM_SIZE    (64),
        .STACK_DEPTH (16)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .halt          (halt),
        .opecode       (opecode),
        .ram_addr      (ram_addr),
        .ram_val       (ram_val),
        .next_ram_addr (next_ram_addr),
        .next_ram_val  (next_ram_val),
        .cout          (cout),
        .rom_addr      (rom_addr),
        .stack_err     (stack_err)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [2:0] enc(input byte c);
        case (c)
            ">": return 3'd1;
            "<": return 3'd2;
            "+": return 3'd3;
            "-": return 3'd4;
            ".": return 3'd5;
            "[": return 3'd6;
            "]": return 3'd7;
            default: return 3'd0;
        endcase
    endfunction

    task automatic load(input string p);
        for (int i = 0; i < 256; i++) rom[i] = 3'd0;
        for (int i = 0; i < p.len(); i++) rom[i] = enc(p[i]);
    endtask

    task automatic clr();
        for (int i = 0; i < 64; i++) mem[i] = 8'd0;
    endtask

    task automatic do_reset();
        halt     = 1'b0;
        ram_addr = 8'd0;
        rst_n    = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // RAM and pointer latch on the falling edge, then the core steps.
    task automatic cyc();
        logic [7:0] a;
        logic [7:0] v;
        @(negedge clk);
        a = next_ram_addr;
        v = next_ram_val;
        mem[ram_addr[5:0]] = v;
        ram_addr = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int backs;
        logic [7:0] prev;

        rst_n    = 1'b0;
        halt     = 1'b0;
        ram_addr = 8'd0;
        clr();
        load("");
        #12;
        check("rst_pc", rom_addr, 0);
        check("rst_err", stack_err, 0);
        check("rst_cout", cout, 0);

        load("+++");
        clr();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            check("inc_val", next_ram_val, i + 1);
            cyc();
            check("inc_pc", rom_addr, i + 1);
        end

        load("<-");
        clr();
        do_reset();
        check("ptr_wrap", next_ram_addr, 63);
        cyc();
        check("dec_wrap", next_ram_val, 255);
        cyc();

        load(".");
        clr();
        mem[0] = 8'h41;
        do_reset();
        check("put_cout", cout, 1);
        check("put_val", next_ram_val, 8'h41);
        cyc();
        check("put_pc", rom_addr, 1);
        check("nop_cout", cout, 0);

        load("+++[-]");
        clr();
        do_reset();
        n = 0;
        backs = 0;
        while (rom_addr != 8'd6 && n < 50) begin
            prev = rom_addr;
            cyc();
            n++;
            if (prev == 8'd5 && rom_addr == 8'd4) backs++;
        end
        check("loop_cycles", n, 10);
        check("loop_backs", backs, 2);
        check("loop_cell", mem[0], 0);

        load("[[+]]+");
        clr();
        do_reset();
        cyc();
        cyc();
        check("skip_val", next_ram_val, 0);
        cyc();
        cyc();
        cyc();
        check("skip_pc", rom_addr, 5);
        check("skip_cell", mem[0], 0);
        check("skip_exit", next_ram_val, 1);

        load("+++[-]");
        clr();
        do_reset();
        repeat (5) cyc();
        check("halt_pre_pc", rom_addr, 5);
        halt = 1'b1;
        #1;
        check("halt_val", next_ram_val, 2);
        check("halt_addr", next_ram_addr, 0);
        repeat (3) cyc();
        check("halt_pc", rom_addr, 5);
        check("halt_cell", mem[0], 2);
        halt = 1'b0;
        cyc();
        check("resume_pc", rom_addr, 4);

        load("[[+]]+");
        clr();
        do_reset();
        cyc();
        cyc();
        check("skip_mid_pc", rom_addr, 2);
        rst_n = 1'b0;
        #1;
        check("rst_async", rom_addr, 0);
        rst_n = 1'b1;
        mem[0] = 8'd5;
        cyc();
        cyc();
        check("rst_exec", next_ram_val, 6);

        load("");
        for (int i = 0; i < 17; i++) rom[i] = 3'd6;
        rom[17] = 3'd7;
        clr();
        mem[0] = 8'd1;
        do_reset();
        repeat (16) cyc();
        check("full_err", stack_err, 0);
        cyc();
        check("ovf_err", stack_err, CHK);
        cyc();
        check("ovf_pc", rom_addr, CHK ? 16 : 17);

        load("]");
        clr();
        do_reset();
        check("unf_pre", stack_err, 0);
        cyc();
        check("unf_pc", rom_addr, 1);
        check("unf_err", stack_err, CHK);
        do_reset();
        check("err_clear", stack_err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
